insn_fetch_queue: RTL and testbench

- Instruction fetch stage directly upstream of the immediate decoder (immx) and the rest of the control unit.
- Generates sequential PCs and issues one-outstanding word requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small FIFO and presents the head entry to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) that flush the FIFO and discard any in-flight fetch.

---
 rtl/insn_fetch_queue.sv | 145 ++++++++++++++
 tb/tb_insn_fetch_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch_queue.sv
// rtl/insn_fetch_queue.sv - sequential instruction fetch with redirect-flushable output FIFO
module insn_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] insn_out,
    output logic [31:0] pc_out,
    output logic        insn_valid,
    input  logic        insn_ready
);

    localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [31:0]     NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_IDLE = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     drop_addr_q, drop_addr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     insn_q [DEPTH];
    logic [31:0]     pc_q   [DEPTH];

    logic            do_push;
    logic            do_pop;
    logic [31:0]     redirect_target;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

    // Outputs: reset blanks the memory request and the decode interface immediately
    always_comb begin
        mem_req    = !reset && (state_q == S_REQ || state_q == S_DROP);
        mem_addr   = (state_q == S_DROP) ? drop_addr_q : fetch_pc_q;
        insn_valid = !reset && (count_q != '0);
        insn_out   = insn_valid ? insn_q[rd_ptr_q] : NOP;
        pc_out     = insn_valid ? pc_q[rd_ptr_q] : 32'h0000_0000;
    end

    // Next-state: redirect flushes the FIFO and either abandons or finishes the in-flight fetch
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        do_push     = 1'b0;
        do_pop      = 1'b0;

        if (redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_target;
            case (state_q)
                S_REQ: begin
                    if (!mem_ack) begin
                        drop_addr_d = fetch_pc_q;
                        state_d     = S_DROP;
                    end
                end
                S_IDLE:  state_d = S_REQ;
                S_DROP:  state_d = mem_ack ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            do_pop  = insn_valid && insn_ready;
            do_push = (state_q == S_REQ) && mem_ack;
            if (do_push) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                S_REQ: begin
                    if (do_push && count_d == FULL) begin
                        state_d = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (count_q < FULL) begin
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // FIFO storage: contents are only meaningful below count_q, so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            insn_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_insn_fetch_queue.sv
// tb/tb_insn_fetch_queue.sv - self-checking bench for insn_fetch_queue
module tb_insn_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] insn_out;
    logic [31:0] pc_out;
    logic        insn_valid;
    logic        insn_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int acks = 0;
    int wait_cnt = 0;
    int cur_lat = 0;
    bit rand_lat = 0;
    bit hold_ack = 0;

    insn_fetch_queue dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .insn_out   (insn_out),
        .pc_out     (pc_out),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0003;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers the current request after cur_lat wait cycles unless held
    task automatic settle();
        #1;
        if (!mem_req) begin
            wait_cnt = 0;
            mem_ack  = 1'b0;
        end else if (hold_ack) begin
            mem_ack = 1'b0;
        end else if (wait_cnt >= cur_lat) begin
            mem_ack  = 1'b1;
            wait_cnt = 0;
            if (rand_lat) cur_lat = $urandom_range(0, 3);
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = wait_cnt + 1;
        end
        mem_rdata = mem_ack ? word_of(mem_addr) : 32'hDEAD_BEEF;
        if (mem_ack) acks = acks + 1;
        #1;
    endtask

    task automatic start_reset();
        reset = 1'b1; redirect = 1'b0; insn_ready = 1'b0;
        hold_ack = 0; rand_lat = 0; cur_lat = 0;
        tick(); settle(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; insn_ready = 1'b1;
        tick(); settle();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", insn_valid); end
        total++; if (insn_out !== NOP) begin bad++; $display("FAIL rst_insn got=%h exp=%h", insn_out, NOP); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
        tick();
        reset = 1'b0;
        settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL rst_first_req got=%b/%h exp=1/0", mem_req, mem_addr); end
    endtask

    task automatic test_stream();
        start_reset();
        insn_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            settle();
            total++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k)) begin bad++; $display("FAIL stream_addr k=%0d got=%b/%h exp=1/%h", k, mem_req, mem_addr, 32'(4 * k)); end
            if (k == 0) begin
                total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL stream_valid0 got=%b exp=0", insn_valid); end
            end else begin
                total++; if (insn_valid !== 1'b1 || pc_out !== 32'(4 * (k - 1)) || insn_out !== word_of(32'(4 * (k - 1)))) begin
                    bad++; $display("FAIL stream_head k=%0d got=%b/%h/%h exp=1/%h/%h", k, insn_valid, pc_out, insn_out, 32'(4 * (k - 1)), word_of(32'(4 * (k - 1))));
                end
            end
        end
    endtask

    task automatic test_full();
        int a0;
        bit found;
        start_reset();
        a0 = acks;
        settle();
        tick(); settle();
        total++; if (mem_addr !== 32'h4 || insn_valid !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL full_second got=%h/%b/%h exp=4/1/0", mem_addr, insn_valid, pc_out); end
        tick(); settle();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_req_low got=%b exp=0", mem_req); end
        tick(); settle();
        total++; if (mem_req !== 1'b0 || acks - a0 != 2) begin bad++; $display("FAIL full_pushes req=%b acks=%0d exp=0/2", mem_req, acks - a0); end
        tick(); insn_ready = 1'b1; settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL full_pop0 got=%b/%h exp=1/0", insn_valid, pc_out); end
        tick(); insn_ready = 1'b0; settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h4) begin bad++; $display("FAIL full_head4 got=%b/%h exp=1/4", insn_valid, pc_out); end
        found = 0;
        for (int i = 0; i < 3 && !found; i++) begin
            if (mem_req) found = 1;
            else begin tick(); settle(); end
        end
        total++; if (!found || mem_addr !== 32'h8) begin bad++; $display("FAIL full_resume found=%b addr=%h exp=1/8", found, mem_addr); end
    endtask

    task automatic test_drop();
        start_reset();
        insn_ready = 1'b1;
        settle();
        tick(); settle();
        tick(); hold_ack = 1; redirect = 1'b1; redirect_pc = 32'h0000_0100; settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin bad++; $display("FAIL drop_w0 got=%b/%h exp=1/8", mem_req, mem_addr); end
        tick(); redirect = 1'b0; settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || insn_valid !== 1'b0) begin bad++; $display("FAIL drop_w1 got=%b/%h/%b exp=1/8/0", mem_req, mem_addr, insn_valid); end
        tick(); settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin bad++; $display("FAIL drop_w2 got=%b/%h exp=1/8", mem_req, mem_addr); end
        tick(); hold_ack = 0; settle();
        total++; if (mem_ack !== 1'b1 || mem_addr !== 32'h8) begin bad++; $display("FAIL drop_ack got=%b/%h exp=1/8", mem_ack, mem_addr); end
        tick(); settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || insn_valid !== 1'b0) begin bad++; $display("FAIL drop_next got=%b/%h/%b exp=1/100/0", mem_req, mem_addr, insn_valid); end
        tick(); settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h100 || insn_out !== word_of(32'h100)) begin bad++; $display("FAIL drop_first got=%b/%h/%h exp=1/100/%h", insn_valid, pc_out, insn_out, word_of(32'h100)); end
    endtask

    task automatic test_redirect_ack();
        start_reset();
        insn_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0102;
        settle();
        total++; if (mem_ack !== 1'b1) begin bad++; $display("FAIL rack_ack got=%b exp=1", mem_ack); end
        tick(); redirect = 1'b0; settle();
        total++; if (insn_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL rack_next got=%b/%b/%h exp=0/1/100", insn_valid, mem_req, mem_addr); end
        tick(); settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h100) begin bad++; $display("FAIL rack_first got=%b/%h exp=1/100", insn_valid, pc_out); end
    endtask

    task automatic test_push_pop();
        start_reset();
        settle();
        tick(); hold_ack = 1; settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h0 || mem_addr !== 32'h4) begin bad++; $display("FAIL pp_one got=%b/%h/%h exp=1/0/4", insn_valid, pc_out, mem_addr); end
        tick(); hold_ack = 0; insn_ready = 1'b1; settle();
        total++; if (mem_ack !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL pp_both got=%b/%h exp=1/0", mem_ack, pc_out); end
        tick(); insn_ready = 1'b0; hold_ack = 1; settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h4 || insn_out !== word_of(32'h4) || mem_addr !== 32'h8) begin bad++; $display("FAIL pp_after got=%b/%h/%h/%h exp=1/4/%h/8", insn_valid, pc_out, insn_out, mem_addr, word_of(32'h4)); end
        tick(); insn_ready = 1'b1; settle();
        tick(); insn_ready = 1'b0; settle();
        total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL pp_count got=%b exp=0", insn_valid); end
        hold_ack = 0;
    endtask

    task automatic test_reset_in_drop();
        start_reset();
        insn_ready = 1'b1;
        settle();
        tick(); settle();
        tick(); hold_ack = 1; redirect = 1'b1; redirect_pc = 32'h0000_0200; settle();
        tick(); redirect = 1'b0; reset = 1'b1; settle();
        total++; if (mem_req !== 1'b0 || insn_valid !== 1'b0 || insn_out !== NOP) begin bad++; $display("FAIL rdrop_rst got=%b/%b/%h exp=0/0/%h", mem_req, insn_valid, insn_out, NOP); end
        tick(); reset = 1'b0; hold_ack = 0; settle();
        total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || insn_valid !== 1'b0) begin bad++; $display("FAIL rdrop_restart got=%b/%h/%b exp=1/0/0", mem_req, mem_addr, insn_valid); end
        tick(); settle();
        total++; if (insn_valid !== 1'b1 || pc_out !== 32'h0) begin bad++; $display("FAIL rdrop_first got=%b/%h exp=1/0", insn_valid, pc_out); end
    endtask

    // Reference: the decoded stream is consecutive words from the last reset/redirect target
    task automatic test_random();
        logic [31:0] exp_pc;
        bit after_redir;
        int pops;
        start_reset();
        rand_lat = 1;
        exp_pc = 32'h0;
        after_redir = 0;
        pops = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                tick();
                reset = ($urandom_range(0, 499) == 0);
            end
            redirect = !reset && ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            insn_ready = ($urandom_range(0, 3) != 0);
            settle();
            if (after_redir && !reset) begin
                total++; if (insn_valid !== 1'b0) begin bad++; $display("FAIL rnd_post_redirect c=%0d got=%b exp=0", c, insn_valid); end
            end
            if (insn_valid === 1'b1) begin
                total++; if (insn_out !== word_of(pc_out)) begin bad++; $display("FAIL rnd_word c=%0d got=%h exp=%h", c, insn_out, word_of(pc_out)); end
            end else begin
                total++; if (insn_out !== NOP || pc_out !== 32'h0) begin bad++; $display("FAIL rnd_empty c=%0d got=%h/%h exp=%h/0", c, insn_out, pc_out, NOP); end
            end
            if (reset) begin
                total++; if (mem_req !== 1'b0 || insn_valid !== 1'b0) begin bad++; $display("FAIL rnd_rst c=%0d got=%b/%b exp=0/0", c, mem_req, insn_valid); end
                exp_pc = 32'h0;
            end else if (redirect) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end else if (insn_valid === 1'b1 && insn_ready) begin
                total++; if (pc_out !== exp_pc) begin bad++; $display("FAIL rnd_order c=%0d got=%h exp=%h", c, pc_out, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            after_redir = redirect && !reset;
        end
        total++; if (pops < 300) begin bad++; $display("FAIL rnd_progress got=%0d exp>=300", pops); end
        redirect = 1'b0; reset = 1'b0; rand_lat = 0; cur_lat = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_drop();
        test_redirect_ack();
        test_push_pop();
        test_reset_in_drop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
